mem_resp_pipe: RTL and testbench

- Pipelined, fixed-latency memory responder. It is the target end of the CPU's memory request interface and replaces the single-cycle instruction/data memory model for the multi-cycle-memory phase of the processor.
- Accepts one read or write request per cycle and executes requests strictly in order.
- Returns exactly one response per request, a fixed LATENCY cycles after acceptance.
- After reset, clears its own storage with a self-initialising sequence before accepting traffic.

---
 rtl/mem_resp_pipe.sv | 153 +++++++++++++++
 tb/tb_mem_resp_pipe.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_resp_pipe.sv
// mem_resp_pipe: fixed-latency, in-order memory responder.
// After reset an INIT sequence zeroes every word, then the block accepts one
// read or write per cycle and returns one response exactly LATENCY cycles later.
//
// Handshake: a request transfers on a rising edge where req_valid & req_ready
// are both high. req_ready is high only in RUN. There is no response
// backpressure: resp_valid is a one-cycle pulse that the initiator must take.
module mem_resp_pipe #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int DEPTH_W = 13,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_wr,
    output logic [ADDR_W-1:0] resp_addr,
    output logic [DATA_W-1:0] resp_data,
    output logic              busy
);

    localparam int WORDS = 1 << DEPTH_W;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [DEPTH_W-1:0]   init_cnt;
    logic                 accept;

    // Signals of the request whose array access happens on this edge.
    logic                 acc_valid;
    logic                 acc_wr;
    logic [ADDR_W-1:0]    acc_addr;
    logic [DATA_W-1:0]    acc_wdata;
    logic [DEPTH_W-1:0]   acc_idx;
    logic                 pipe_busy;

    logic [DATA_W-1:0]    mem [WORDS];

    assign accept  = req_valid & req_ready;
    assign acc_idx = acc_addr[DEPTH_W:1];

    // State register and INIT word counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + 1'b1;
            end
        end
    end

    // Next state: leave INIT after the last word has been cleared; RUN is terminal.
    always_comb begin
        state_nxt = state;
        if (state == ST_INIT && init_cnt == '1) begin
            state_nxt = ST_RUN;
        end
    end

    // FSM outputs: accept only in RUN, busy while clearing or anything in flight.
    always_comb begin
        req_ready = (state == ST_RUN);
        busy      = (state == ST_INIT) | pipe_busy | resp_valid;
    end

    generate
        if (LATENCY == 1) begin : g_direct
            // The access happens on the accept edge itself.
            assign acc_valid = accept;
            assign acc_wr    = req_wr;
            assign acc_addr  = req_addr;
            assign acc_wdata = req_wdata;
            assign pipe_busy = 1'b0;
        end else begin : g_pipe
            localparam int NSTG = LATENCY - 1;
            logic [NSTG-1:0]   stg_valid;
            logic [NSTG-1:0]   stg_wr;
            logic [ADDR_W-1:0] stg_addr  [NSTG];
            logic [DATA_W-1:0] stg_wdata [NSTG];

            // Delay line of accepted requests; reset drops everything in flight.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stg_valid <= '0;
                    stg_wr    <= '0;
                    for (int i = 0; i < NSTG; i++) begin
                        stg_addr[i]  <= '0;
                        stg_wdata[i] <= '0;
                    end
                end else begin
                    stg_valid[0] <= accept;
                    stg_wr[0]    <= req_wr;
                    stg_addr[0]  <= req_addr;
                    stg_wdata[0] <= req_wdata;
                    for (int i = 1; i < NSTG; i++) begin
                        stg_valid[i] <= stg_valid[i-1];
                        stg_wr[i]    <= stg_wr[i-1];
                        stg_addr[i]  <= stg_addr[i-1];
                        stg_wdata[i] <= stg_wdata[i-1];
                    end
                end
            end

            assign acc_valid = stg_valid[NSTG-1];
            assign acc_wr    = stg_wr[NSTG-1];
            assign acc_addr  = stg_addr[NSTG-1];
            assign acc_wdata = stg_wdata[NSTG-1];
            assign pipe_busy = |stg_valid;
        end
    endgenerate

    // Storage: INIT clears one word per edge; in RUN the head request writes.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[init_cnt] <= '0;
        end else if (acc_valid && acc_wr) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    // Response registers, loaded on the same edge as the array access.
    // A read sees every earlier write because those committed on earlier edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_wr    <= 1'b0;
            resp_addr  <= '0;
            resp_data  <= '0;
        end else begin
            resp_valid <= acc_valid;
            if (acc_valid) begin
                resp_wr   <= acc_wr;
                resp_addr <= acc_addr;
                resp_data <= acc_wr ? acc_wdata : mem[acc_idx];
            end
        end
    end

endmodule

// File: tb/tb_mem_resp_pipe.sv
// Bench for mem_resp_pipe with a small array (16 words) and LATENCY 4.
module tb_mem_resp_pipe;

    localparam int DW  = 16;
    localparam int AW  = 16;
    localparam int DPW = 4;
    localparam int LAT = 4;
    localparam int NW  = 1 << DPW;
    localparam int EW  = 32 + 1 + AW + DW;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic          resp_wr;
    logic [AW-1:0] resp_addr;
    logic [DW-1:0] resp_data;
    logic          busy;

    mem_resp_pipe #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .DEPTH_W(DPW),
        .LATENCY(LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_wr   (resp_wr),
        .resp_addr (resp_addr),
        .resp_data (resp_data),
        .busy      (busy)
    );

    // Clock and reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: word array, INIT countdown and response scoreboard.
    // Entries are {cycle, wr, addr, data}.
    logic [DW-1:0] model_mem [NW];
    int            init_left;
    int            cyc;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] obs_q[$];
    int            n_checks;
    int            n_fail;

    // Driver tasks.
    task automatic drive(input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid = v;
        req_wr    = w;
        req_addr  = a;
        req_wdata = d;
    endtask

    task automatic drive_idle();
        drive(1'b0, 1'b0, '0, '0);
    endtask

    // Advance one clock; the model accepts what was presented, then the
    // DUT outputs of the new cycle are sampled 1 ns after the edge.
    task automatic step();
        logic          acc;
        logic [DPW-1:0] idx;
        logic [31:0]   due;
        acc = rst_n && req_valid && (init_left == 0);
        idx = req_addr[DPW:1];
        due = 32'(cyc + LAT);
        @(posedge clk);
        if (acc) begin
            if (req_wr) begin
                model_mem[idx] = req_wdata;
                exp_q.push_back({due, 1'b1, req_addr, req_wdata});
            end else begin
                exp_q.push_back({due, 1'b0, req_addr, model_mem[idx]});
            end
        end else if (rst_n && init_left > 0) begin
            init_left--;
        end
        cyc++;
        #1;
        if (resp_valid === 1'b1) obs_q.push_back({32'(cyc), resp_wr, resp_addr, resp_data});
    endtask

    // Assert reset mid-cycle, hold it over two edges, release mid-cycle.
    task automatic apply_reset();
        rst_n = 1'b0;
        drive_idle();
        exp_q.delete();
        #1;
        n_checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_async: valid=%b ready=%b busy=%b, need 0 0 1", resp_valid, req_ready, busy);
        end
        step();
        step();
        for (int i = 0; i < NW; i++) model_mem[i] = '0;
        init_left = NW;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        cyc = 0;
        #2;
        n_checks++;
        if (resp_valid !== 1'b0 || resp_wr !== 1'b0 || resp_addr !== '0 || resp_data !== '0 ||
            req_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_values: v=%b w=%b a=%h d=%h rdy=%b busy=%b, need 0 0 0 0 0 1",
                     resp_valid, resp_wr, resp_addr, resp_data, req_ready, busy);
        end
        apply_reset();
        for (int i = 0; i < NW; i++) begin
            n_checks++;
            if (req_ready !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL init_cycle%0d: ready=%b busy=%b, need 0 1", i, req_ready, busy);
            end
            drive(1'b1, 1'b1, 16'h0000, 16'hdead);  // ignored during INIT
            step();
        end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL init_done: ready=%b, need 1", req_ready);
        end
        for (int i = 0; i < NW; i++) begin
            drive(1'b1, 1'b0, 16'(2 * i), '0);
            step();
        end
        drive_idle();
        repeat (LAT + 1) step();
        n_checks++;
        if (obs_q.size() != NW || exp_q.size() != NW) begin
            n_fail++;
            $display("FAIL init_read_count: got %0d, need %0d", obs_q.size(), NW);
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i] || obs_q[i][DW-1:0] !== '0) begin
                n_fail++;
                $display("FAIL init_read%0d: got %h, need %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_write_read();
        int n;
        n = cyc;
        drive(1'b1, 1'b1, 16'h0006, 16'h1234);
        step();
        drive_idle();
        while (cyc < n + LAT) step();
        n_checks++;
        if (resp_valid !== 1'b1 || resp_wr !== 1'b1 || resp_addr !== 16'h0006 || resp_data !== 16'h1234) begin
            n_fail++;
            $display("FAIL wr_resp: v=%b w=%b a=%h d=%h, need 1 1 0006 1234", resp_valid, resp_wr, resp_addr, resp_data);
        end
        step();
        drive(1'b1, 1'b0, 16'h0006, 16'h0000);
        step();
        drive_idle();
        repeat (LAT + 1) step();
        n_checks++;
        if (obs_q.size() != 2 || exp_q.size() != 2) begin
            n_fail++;
            $display("FAIL wr_rd_count: got %0d, need 2", obs_q.size());
        end else if (obs_q[1][DW-1:0] !== 16'h1234) begin
            n_fail++;
            $display("FAIL wr_rd_data: got %h, need 1234", obs_q[1][DW-1:0]);
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL wr_rd%0d: got %h, need %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] want [4];
        want[0] = 16'hbeef; want[1] = 16'hbeef; want[2] = 16'h0001; want[3] = 16'h0001;
        drive(1'b1, 1'b1, 16'h0008, 16'hbeef); step();
        drive(1'b1, 1'b0, 16'h0008, 16'h0000); step();
        drive(1'b1, 1'b1, 16'h0008, 16'h0001); step();
        drive(1'b1, 1'b0, 16'h0008, 16'h0000); step();
        drive_idle();
        repeat (LAT + 1) step();
        n_checks++;
        if (obs_q.size() != 4 || exp_q.size() != 4) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d, need 4", obs_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i] || obs_q[i][DW-1:0] !== want[i]) begin
                n_fail++;
                $display("FAIL b2b%0d: got %h, need %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_alias();
        drive(1'b1, 1'b1, 16'h0022, 16'ha5a5); step();
        drive(1'b1, 1'b0, 16'h0002, 16'h0000); step();
        drive(1'b1, 1'b0, 16'h0003, 16'h0000); step();
        drive_idle();
        repeat (LAT + 1) step();
        n_checks++;
        if (obs_q.size() != 3 || exp_q.size() != 3) begin
            n_fail++;
            $display("FAIL alias_count: got %0d, need 3", obs_q.size());
        end else if (obs_q[1][DW-1:0] !== 16'ha5a5 || obs_q[2][DW-1:0] !== 16'ha5a5 ||
                     obs_q[1][DW+AW-1:DW] !== 16'h0002 || obs_q[2][DW+AW-1:DW] !== 16'h0003) begin
            n_fail++;
            $display("FAIL alias_data: got %h %h, need addr 0002/0003 data a5a5", obs_q[1], obs_q[2]);
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL alias%0d: got %h, need %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_stream();
        int last_due;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 16'(2 * i), '0);
            step();
        end
        drive_idle();
        last_due = cyc - 1 + LAT;
        while (cyc < last_due) step();
        n_checks++;
        if (resp_valid !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_last: valid=%b busy=%b, need 1 1", resp_valid, busy);
        end
        step();
        n_checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_idle: valid=%b busy=%b, need 0 0", resp_valid, busy);
        end
        n_checks++;
        if (obs_q.size() != 8 || exp_q.size() != 8) begin
            n_fail++;
            $display("FAIL stream_count: got %0d, need 8", obs_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL stream%0d: got %h, need %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, 65535)), DW'($urandom));
            step();
        end
        drive_idle();
        repeat (LAT + 1) step();
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_count: got %0d, need %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rand%0d: got %h, need %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_inflight();
        drive(1'b1, 1'b1, 16'h000c, 16'h5555); step();
        drive_idle();
        repeat (LAT + 1) step();
        obs_q.delete();
        exp_q.delete();
        drive(1'b1, 1'b0, 16'h000c, 16'h0000); step();
        drive(1'b1, 1'b1, 16'h000c, 16'h7777); step();
        drive(1'b1, 1'b0, 16'h0004, 16'h0000); step();
        apply_reset();
        for (int i = 0; i < NW; i++) begin
            n_checks++;
            if (req_ready !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL reinit_cycle%0d: ready=%b busy=%b, need 0 1", i, req_ready, busy);
            end
            step();
        end
        drive(1'b1, 1'b0, 16'h000c, 16'h0000);
        step();
        drive_idle();
        repeat (LAT + 1) step();
        n_checks++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            n_fail++;
            $display("FAIL rst_flight_count: got %0d, need 1", obs_q.size());
        end else if (obs_q[0] !== exp_q[0] || obs_q[0][DW-1:0] !== '0) begin
            n_fail++;
            $display("FAIL rst_flight_read: got %h, need %h", obs_q[0], exp_q[0]);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        init_left = NW;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_alias();
        test_stream();
        test_random();
        test_reset_inflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
